alu_cmd_sequencer: RTL
======================

Name: alu_cmd_sequencer

Overview:
- Initiator side of the 8-bit ALU interface; the ALU is the combinational responder.
- Accepts ALU commands over a valid/ready stream and buffers them in a small FIFO.
- Drives a/b/op to the ALU, holds them stable for a settle window, captures result/zero/overflow, and returns a response over a valid/ready stream.
- Keeps an 8-bit accumulator so that RGB-mixer channel arithmetic can be chained without host round-trips.

Parameters:
DEPTH, 4, command FIFO entries; power of 2, >=2
SETTLE, 1, cycles ALU inputs are held before capture; >=1

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  FIFO not full; push when cmd_valid&&cmd_ready
cmd_op  input  3  ALU opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 illegal
cmd_a  input  8  operand A, used when cmd_sel_acc=0
cmd_b  input  8  operand B
cmd_sel_acc  input  1  1: operand A = accumulator
cmd_acc_wr  input  1  1: write result into accumulator
alu_a  output  8  to ALU a
alu_b  output  8  to ALU b
alu_op  output  3  to ALU op
alu_result  input  8  from ALU result
alu_zero  input  1  from ALU zero
alu_overflow  input  1  from ALU overflow
rsp_valid  output  1  response held until accepted
rsp_ready  input  1  response consumer ready
rsp_data  output  8  captured result
rsp_zero  output  1  captured zero flag
rsp_ovf  output  1  captured overflow flag
rsp_err  output  1  illegal opcode
acc_out  output  8  current accumulator

Behaviour:
- Reset (async assert, sync-safe deassert): FIFO empty, state IDLE, acc=0, all outputs 0 except cmd_ready=1. Assertion mid-operation discards FIFO contents and the in-flight command; rsp_valid drops immediately.
- FIFO: stores {op,a,b,sel_acc,acc_wr}. Push and pop may occur in the same cycle. No push when full (cmd_ready=0). Pointers wrap modulo DEPTH.
- FSM states IDLE, ISSUE, RESP.
- IDLE: if FIFO is non-empty, pop at this edge.
  - Legal op: load alu_a = sel_acc ? acc : a, alu_b = b, alu_op = op. Load settle counter with SETTLE-1. Go to ISSUE.
  - op=111: leave alu_* unchanged. Set rsp_data=0, rsp_zero=0, rsp_ovf=0, rsp_err=1. Go to RESP.
- ISSUE: alu_* held constant.
  - Counter != 0: decrement.
  - Counter == 0: capture alu_result/alu_zero/alu_overflow into rsp_data/rsp_zero/rsp_ovf and set rsp_err=0. If acc_wr, acc <= alu_result at the same edge. Go to RESP.
- RESP: rsp_valid=1 with all rsp_* stable. On rsp_valid&&rsp_ready, go to IDLE and deassert rsp_valid. The next pop occurs at the following edge, so at most one command is in flight.
- alu_* retain the last issued values outside ISSUE (no glitching back to 0).
- Latency from a command accepted at edge E0 into an empty FIFO with FSM in IDLE:
  - Legal op: rsp_valid high after edge E0+SETTLE+1.
  - Illegal op: rsp_valid high after edge E0+1.
- Capacity while rsp_ready=0: DEPTH commands in the FIFO plus one in flight, i.e. DEPTH+1 are accepted before cmd_ready stays low.
- sel_acc reads the accumulator value at pop time. This includes a value written by the immediately preceding command.
- Arithmetic is entirely in the ALU. The sequencer passes flags through unmodified and never alters rsp_data.

Test Plan:
- Push ADD a=0x30 b=0x12 sel_acc=0 acc_wr=1 at E0, rsp_ready=1 -> alu_a=0x30, alu_b=0x12, alu_op=000 after E1. rsp_valid after E2 with rsp_data=0x42, rsp_zero=0, rsp_err=0. acc_out=0x42.
- Follow with SUB sel_acc=1 b=0x42 acc_wr=1 -> alu_a=0x42, rsp_data=0x00, rsp_zero=1, acc_out=0x00. Then OR sel_acc=1 b=0xA5 acc_wr=0 -> rsp_data=0xA5, acc_out stays 0x00.
- Push op=111 a=0xFF b=0xFF acc_wr=1 -> rsp_valid after E0+1, rsp_err=1, rsp_data=0. alu_* and acc_out unchanged.
- rsp_ready=0, offer 8 back-to-back commands (DEPTH=4) -> exactly 5 accepted, then cmd_ready=0. Release rsp_ready -> 5 responses in push order with correct data, and cmd_ready re-asserts after the first response handshake.
- SETTLE=3; bench ALU model changes alu_result from 0x11 to 0x22 two cycles after issue -> captured rsp_data=0x22, rsp_valid after E0+4.
- Assert rst_n low while in ISSUE with 3 commands queued -> rsp_valid=0, cmd_ready=1, acc_out=0 immediately. After release, no stale responses appear and a new ADD 0x01+0x01 returns 0x02.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
//
// Initiator side of the 8-bit ALU interface. Commands arrive on a valid/ready
// stream and are buffered in a small FIFO. One command at a time is popped.
// Its operands and opcode are driven to the combinational ALU and held for a
// settle window. The ALU result and flags are then captured and returned on
// a valid/ready response stream. An 8-bit accumulator lets the host chain
// operations (for example RGB-mixer channel arithmetic) without a round trip.
//
// Parameters
//   DEPTH   command FIFO entries (power of 2, >= 2)
//   SETTLE  cycles the ALU inputs are held before capture (>= 1)
//
// Ports
//   clk, rst_n                    clock; asynchronous active-low reset
//   cmd_valid/cmd_ready           command stream handshake
//   cmd_op/cmd_a/cmd_b            opcode and operands (op 3'b111 is illegal)
//   cmd_sel_acc                   1: operand A is the accumulator
//   cmd_acc_wr                    1: write the ALU result into the accumulator
//   alu_a/alu_b/alu_op            drive to the ALU, held between commands
//   alu_result/zero/overflow      combinational ALU response
//   rsp_valid/rsp_ready           response stream handshake
//   rsp_data/zero/ovf/err         captured result, flags, illegal-op marker
//   acc_out                       current accumulator value
//
// rst_n is asserted asynchronously. The system is expected to release it
// synchronously to clk, so no internal reset synchroniser is present.
// -----------------------------------------------------------------------------
module alu_cmd_sequencer #(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    input  logic       cmd_sel_acc,
    input  logic       cmd_acc_wr,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [7:0] alu_result,
    input  logic       alu_zero,
    input  logic       alu_overflow,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_zero,
    output logic       rsp_ovf,
    output logic       rsp_err,
    output logic [7:0] acc_out
);

    localparam int              PW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [PW:0]     FULL_CNT    = (PW + 1)'(DEPTH);
    localparam logic [CW-1:0]   SETTLE_LOAD = CW'(SETTLE - 1);
    localparam logic [2:0]      OP_ILLEGAL  = 3'b111;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       sel_acc;
        logic       acc_wr;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Command FIFO
    // -------------------------------------------------------------------------
    cmd_t          mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;

    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;
    cmd_t wr_entry;
    cmd_t head;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && !fifo_full;
    assign wr_entry   = {cmd_op, cmd_a, cmd_b, cmd_sel_acc, cmd_acc_wr};
    // The head is read combinationally so a pop in IDLE can load the ALU
    // drive registers at the same edge.
    assign head       = mem_q[rd_ptr_q];

    // Storage carries no reset: stale entries are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Sequencer FSM
    // -------------------------------------------------------------------------
    state_t        state_q,    state_d;
    logic [7:0]    alu_a_q,    alu_a_d;
    logic [7:0]    alu_b_q,    alu_b_d;
    logic [2:0]    alu_op_q,   alu_op_d;
    logic [CW-1:0] settle_q,   settle_d;
    logic          acc_wr_q,   acc_wr_d;
    logic [7:0]    acc_q,      acc_d;
    logic [7:0]    rsp_data_q, rsp_data_d;
    logic          rsp_zero_q, rsp_zero_d;
    logic          rsp_ovf_q,  rsp_ovf_d;
    logic          rsp_err_q,  rsp_err_d;

    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        settle_d   = settle_q;
        acc_wr_d   = acc_wr_q;
        acc_d      = acc_q;
        rsp_data_d = rsp_data_q;
        rsp_zero_d = rsp_zero_q;
        rsp_ovf_d  = rsp_ovf_q;
        rsp_err_d  = rsp_err_q;
        pop        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head.op == OP_ILLEGAL) begin
                        // Rejected without touching the ALU drive or the
                        // accumulator; answered straight away.
                        rsp_data_d = 8'h00;
                        rsp_zero_d = 1'b0;
                        rsp_ovf_d  = 1'b0;
                        rsp_err_d  = 1'b1;
                        state_d    = ST_RESP;
                    end else begin
                        // All earlier commands have completed, so acc_q
                        // already holds any value the previous one wrote.
                        alu_a_d  = head.sel_acc ? acc_q : head.a;
                        alu_b_d  = head.b;
                        alu_op_d = head.op;
                        acc_wr_d = head.acc_wr;
                        settle_d = SETTLE_LOAD;
                        state_d  = ST_ISSUE;
                    end
                end
            end

            ST_ISSUE: begin
                if (settle_q != '0) begin
                    settle_d = settle_q - 1'b1;
                end else begin
                    rsp_data_d = alu_result;
                    rsp_zero_d = alu_zero;
                    rsp_ovf_d  = alu_overflow;
                    rsp_err_d  = 1'b0;
                    if (acc_wr_q) begin
                        acc_d = alu_result;
                    end
                    state_d = ST_RESP;
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            alu_a_q    <= 8'h00;
            alu_b_q    <= 8'h00;
            alu_op_q   <= 3'b000;
            settle_q   <= '0;
            acc_wr_q   <= 1'b0;
            acc_q      <= 8'h00;
            rsp_data_q <= 8'h00;
            rsp_zero_q <= 1'b0;
            rsp_ovf_q  <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            settle_q   <= settle_d;
            acc_wr_q   <= acc_wr_d;
            acc_q      <= acc_d;
            rsp_data_q <= rsp_data_d;
            rsp_zero_q <= rsp_zero_d;
            rsp_ovf_q  <= rsp_ovf_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // rsp_valid decodes straight from the state register so that reset
    // removes it without waiting for a clock edge.
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_ovf   = rsp_ovf_q;
    assign rsp_err   = rsp_err_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign acc_out   = acc_q;

endmodule
